// File: rtl/decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : Registered instruction-decode stage with a 2-entry skid buffer,
//             synchronous flush and a wrapping retired-decode counter.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int INSTR_W  = 16,
    parameter int OPCODE_W = 4,
    parameter int REG_W    = 3,
    parameter int DATA_W   = 16,
    parameter int PC_W     = 16,
    parameter logic [OPCODE_W-1:0] OP_R_TYPE = '0,
    parameter logic [OPCODE_W-1:0] OP_J      = 4'hC,
    parameter logic [OPCODE_W-1:0] OP_JAL    = 4'hD,
    parameter logic [OPCODE_W-1:0] OP_JR     = 4'hE,
    parameter logic [REG_W-1:0]    LINK_REG  = 3'd7,
    parameter int CNT_W    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INSTR_W-1:0]              in_instr,
    input  logic [PC_W-1:0]                 in_pc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OPCODE_W-1:0]             out_opcode,
    output logic [REG_W-1:0]                out_rs,
    output logic [REG_W-1:0]                out_rt,
    output logic [REG_W-1:0]                out_rd,
    output logic [INSTR_W-OPCODE_W-3*REG_W-1:0] out_funct,
    output logic [DATA_W-1:0]               out_imm,
    output logic [INSTR_W-OPCODE_W-1:0]     out_jtarget,
    output logic                            out_is_r,
    output logic                            out_is_i,
    output logic                            out_is_j,
    output logic                            out_wr_en,
    output logic [REG_W-1:0]                out_wr_reg,
    output logic [PC_W-1:0]                 out_pc,
    output logic [CNT_W-1:0]                decode_count
);

    localparam int FUNCT_W = INSTR_W - OPCODE_W - 3*REG_W;
    localparam int IMM_W   = INSTR_W - OPCODE_W - 2*REG_W;
    localparam int JT_W    = INSTR_W - OPCODE_W;

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [FUNCT_W-1:0]  funct;
        logic [DATA_W-1:0]   imm;
        logic [JT_W-1:0]     jtarget;
        logic                is_r;
        logic                is_i;
        logic                is_j;
        logic                wr_en;
        logic [REG_W-1:0]    wr_reg;
        logic [PC_W-1:0]     pc;
    } entry_t;

    logic [1:0]        r_state;
    entry_t            r_main;
    entry_t            r_skid;
    logic              r_rdy_en;
    logic [CNT_W-1:0]  r_count;

    entry_t            w_dec;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_accept;
    logic              w_hs;

    generate
        if (DATA_W > IMM_W) begin : g_imm_sext
            assign w_imm_ext = {{(DATA_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
        end else begin : g_imm_trunc
            assign w_imm_ext = in_instr[DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        w_dec         = '0;
        w_dec.opcode  = in_instr[INSTR_W-1 -: OPCODE_W];
        w_dec.rs      = in_instr[INSTR_W-OPCODE_W-1 -: REG_W];
        w_dec.rt      = in_instr[INSTR_W-OPCODE_W-REG_W-1 -: REG_W];
        w_dec.rd      = in_instr[INSTR_W-OPCODE_W-2*REG_W-1 -: REG_W];
        w_dec.funct   = in_instr[FUNCT_W-1:0];
        w_dec.imm     = w_imm_ext;
        w_dec.jtarget = in_instr[JT_W-1:0];
        w_dec.pc      = in_pc;
        w_dec.is_r    = (w_dec.opcode == OP_R_TYPE);
        w_dec.is_j    = (w_dec.opcode == OP_J) || (w_dec.opcode == OP_JAL) ||
                        (w_dec.opcode == OP_JR);
        w_dec.is_i    = !(w_dec.is_r || w_dec.is_j);
        if (w_dec.is_r) begin
            w_dec.wr_en  = 1'b1;
            w_dec.wr_reg = w_dec.rd;
        end else if (w_dec.opcode == OP_JAL) begin
            w_dec.wr_en  = 1'b1;
            w_dec.wr_reg = LINK_REG;
        end else if (w_dec.is_j) begin
            w_dec.wr_en  = 1'b0;
            w_dec.wr_reg = '0;
        end else begin
            w_dec.wr_en  = 1'b1;
            w_dec.wr_reg = w_dec.rt;
        end
    end

    // in_ready stays low during reset and until the first edge after it.
    assign in_ready  = r_rdy_en && (r_state != c_FULL);
    assign out_valid = (r_state != c_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_hs      = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_EMPTY;
            r_main   <= '0;
            r_skid   <= '0;
            r_rdy_en <= 1'b0;
            r_count  <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (flush) begin
                r_state <= c_EMPTY;
            end else begin
                case (r_state)
                    c_EMPTY: begin
                        if (w_accept) begin
                            r_main  <= w_dec;
                            r_state <= c_ONE;
                        end
                    end
                    c_ONE: begin
                        if (w_accept && !w_hs) begin
                            r_skid  <= w_dec;
                            r_state <= c_FULL;
                        end else if (w_accept && w_hs) begin
                            r_main  <= w_dec;
                            r_state <= c_ONE;
                        end else if (w_hs) begin
                            r_state <= c_EMPTY;
                        end
                    end
                    c_FULL: begin
                        if (w_hs) begin
                            r_main  <= r_skid;
                            r_state <= c_ONE;
                        end
                    end
                    default: r_state <= c_EMPTY;
                endcase
                if (w_hs) begin
                    r_count <= r_count + c_CNT_ONE;
                end
            end
        end
    end

    assign out_opcode   = r_main.opcode;
    assign out_rs       = r_main.rs;
    assign out_rt       = r_main.rt;
    assign out_rd       = r_main.rd;
    assign out_funct    = r_main.funct;
    assign out_imm      = r_main.imm;
    assign out_jtarget  = r_main.jtarget;
    assign out_is_r     = r_main.is_r;
    assign out_is_i     = r_main.is_i;
    assign out_is_j     = r_main.is_j;
    assign out_wr_en    = r_main.wr_en;
    assign out_wr_reg   = r_main.wr_reg;
    assign out_pc       = r_main.pc;
    assign decode_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Directed scoreboard bench for decode_stage (CNT_W = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rs, out_rt, out_rd, out_funct;
    logic [15:0] out_imm;
    logic [11:0] out_jtarget;
    logic        out_is_r, out_is_i, out_is_j, out_wr_en;
    logic [2:0]  out_wr_reg;
    logic [15:0] out_pc;
    logic [3:0]  decode_count;

    decode_stage #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_funct(out_funct), .out_imm(out_imm), .out_jtarget(out_jtarget),
        .out_is_r(out_is_r), .out_is_i(out_is_i), .out_is_j(out_is_j),
        .out_wr_en(out_wr_en), .out_wr_reg(out_wr_reg),
        .out_pc(out_pc), .decode_count(decode_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  rs, rt, rd, fn;
        logic [15:0] imm;
        logic [11:0] jt;
        logic [2:0]  flags;
        logic        wen;
        logic [2:0]  wreg;
        logic [15:0] pc;
    } exp_t;

    exp_t       q[$];
    logic [3:0] cnt;
    logic       rdy_en;
    logic       acc;
    int         total = 0;
    int         bad   = 0;
    logic [3:0] saved_cnt;

    function automatic exp_t model(input logic [15:0] ins, input logic [15:0] pc);
        exp_t e;
        e.op  = ins[15:12];
        e.rs  = ins[11:9];
        e.rt  = ins[8:6];
        e.rd  = ins[5:3];
        e.fn  = ins[2:0];
        e.imm = {{10{ins[5]}}, ins[5:0]};
        e.jt  = ins[11:0];
        e.pc  = pc;
        if (e.op == 4'h0) begin
            e.flags = 3'b100; e.wen = 1'b1; e.wreg = e.rd;
        end else if (e.op == 4'hD) begin
            e.flags = 3'b001; e.wen = 1'b1; e.wreg = 3'd7;
        end else if (e.op == 4'hC || e.op == 4'hE) begin
            e.flags = 3'b001; e.wen = 1'b0; e.wreg = 3'd0;
        end else begin
            e.flags = 3'b010; e.wen = 1'b1; e.wreg = e.rt;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 0);
        chk({tag, "_count"}, {28'd0, decode_count}, 0);
        chk({tag, "_fields"}, {16'd0, out_opcode, out_rs, out_rt, out_rd, out_funct}, 0);
        chk({tag, "_imm"}, {16'd0, out_imm}, 0);
        chk({tag, "_jt_pc"}, {4'd0, out_jtarget, out_pc}, 0);
        chk({tag, "_flags"}, {25'd0, out_is_r, out_is_i, out_is_j, out_wr_en, out_wr_reg}, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_low_after_rst", {31'd0, in_ready}, 0);
        q.delete();
        cnt    = 4'd0;
        rdy_en = 1'b1;
    endtask

    task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                        input logic ordy, input logic fl, output logic accepted);
        logic exp_rdy;
        logic hs;
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = rdy_en && (q.size() < 2);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("decode_count", {28'd0, decode_count}, {28'd0, cnt});
        if (q.size() != 0) begin
            chk("opcode", {28'd0, out_opcode}, {28'd0, q[0].op});
            chk("regs", {20'd0, out_rs, out_rt, out_rd, out_funct},
                {20'd0, q[0].rs, q[0].rt, q[0].rd, q[0].fn});
            chk("imm", {16'd0, out_imm}, {16'd0, q[0].imm});
            chk("jtarget", {20'd0, out_jtarget}, {20'd0, q[0].jt});
            chk("type_flags", {29'd0, out_is_r, out_is_i, out_is_j}, {29'd0, q[0].flags});
            chk("wr_dest", {28'd0, out_wr_en, out_wr_reg}, {28'd0, q[0].wen, q[0].wreg});
            chk("pc", {16'd0, out_pc}, {16'd0, q[0].pc});
        end
        accepted = v && exp_rdy && !fl;
        hs = (q.size() != 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (hs) begin
                void'(q.pop_front());
                cnt = cnt + 4'd1;
            end
            if (v && exp_rdy) q.push_back(model(ins, pc));
        end
        rdy_en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b0; cnt = '0; rdy_en = 1'b0;
        #2;
        reset_checks("por");
        release_reset();

        // Single instructions of each type with the consumer always ready.
        step(1'b1, 16'h0A5B, 16'h0100, 1'b1, 1'b0, acc);
        step(1'b1, 16'h1A7E, 16'h0102, 1'b1, 1'b0, acc);
        step(1'b1, 16'hD123, 16'h0104, 1'b1, 1'b0, acc);
        step(1'b1, 16'hC456, 16'h0106, 1'b1, 1'b0, acc);
        step(1'b1, 16'hE0F8, 16'h0108, 1'b1, 1'b0, acc);
        step(1'b1, 16'h2A1F, 16'h010A, 1'b1, 1'b0, acc);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, acc);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, acc);

        // Back-pressure: two accepted, third waits until the buffer drains.
        step(1'b1, 16'h4111, 16'h0200, 1'b0, 1'b0, acc);
        step(1'b1, 16'h5222, 16'h0202, 1'b0, 1'b0, acc);
        step(1'b1, 16'h6333, 16'h0204, 1'b0, 1'b0, acc);
        chk("full_rejects", {31'd0, acc}, 0);
        step(1'b1, 16'h6333, 16'h0204, 1'b0, 1'b0, acc);
        begin
            int tries = 0;
            acc = 1'b0;
            while (!acc && tries < 6) begin
                step(1'b1, 16'h6333, 16'h0204, 1'b1, 1'b0, acc);
                tries++;
            end
            chk("third_accept_tries", tries, 2);
        end
        repeat (3) step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, acc);

        // Flush while FULL with a same-cycle offer and handshake.
        step(1'b1, 16'h7444, 16'h0300, 1'b0, 1'b0, acc);
        step(1'b1, 16'h8555, 16'h0302, 1'b0, 1'b0, acc);
        saved_cnt = decode_count;
        step(1'b1, 16'h9666, 16'h0304, 1'b1, 1'b1, acc);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, acc);
        chk("flush_count_held", {28'd0, decode_count}, {28'd0, saved_cnt});
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, acc);

        // Counter wrap: 18 handshakes from reset leave a 4-bit count at 2.
        rst = 1'b1;
        #1;
        reset_checks("rst2");
        release_reset();
        for (int i = 0; i < 18; i++)
            step(1'b1, 16'($urandom), 16'(i * 2), 1'b1, 1'b0, acc);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, acc);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, acc);
        chk("count_wrap", {28'd0, decode_count}, 2);

        // Asynchronous reset between edges while FULL.
        step(1'b1, 16'h3ABC, 16'h0400, 1'b0, 1'b0, acc);
        step(1'b1, 16'hD7FF, 16'h0402, 1'b0, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        reset_checks("arst");
        release_reset();
        step(1'b1, 16'h0A5B, 16'h0500, 1'b1, 1'b0, acc);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, acc);
        step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
